// File: rtl/router_fifo_if.sv
// Handshake/data bundle between the synchroniser side (master) and one router_fifo (slave).
// The err flag is present only when ROUTER_FIFO_ERR_FLAG_EN is defined.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    logic             err;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, err
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, err
    );
`else
    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
`endif
endinterface

// File: rtl/router_fifo.sv
// Per-port 1x3 router output buffer with packet byte counter; sticky err via ROUTER_FIFO_ERR_FLAG_EN.
// Read data 1 cycle after read_enb; writes while full and reads while empty are dropped.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    router_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic [6:0]       r_count;
    logic [WIDTH-1:0] r_data_out;

    logic             w_empty;
    logic             w_full;
    logic             w_clear;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH:0]   w_rd_word;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                       (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_clear   = i_reset || bus.soft_reset;
    assign w_wr_acc  = bus.write_enb && !w_full && !w_clear;
    assign w_rd_acc  = bus.read_enb && !w_empty && !w_clear;
    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge i_clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_data_out <= w_rd_word[WIDTH-1:0];
                // Header reload covers payload bytes plus the trailing parity byte.
                if (w_rd_word[WIDTH]) begin
                    r_count <= 7'(w_rd_word[WIDTH-1:2]) + 7'd1;
                end else if (r_count != 7'd0) begin
                    r_count <= r_count - 7'd1;
                end
            end else if (r_count == 7'd0) begin
                r_data_out <= '0;
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;

`ifdef ROUTER_FIFO_ERR_FLAG_EN
    logic r_err;

    always_ff @(posedge i_clock) begin
        if (w_clear) begin
            r_err <= 1'b0;
        end else if ((bus.write_enb && w_full) || (bus.read_enb && w_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif

endmodule
